// File: rtl/red_seq_unit.sv
// Multi-cycle lane reduction: sums every LANE_W-bit lane of A and B,
// LANES_PER_CYC lane pairs per clock, behind valid/ready handshakes.
module red_seq_unit #(
   parameter int DATA_W        = 16,
   parameter int LANE_W        = 4,
   parameter int LANES_PER_CYC = 2,
   parameter int OUT_W         = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_a,
   input  logic [DATA_W-1:0] in_b,
   input  logic              in_signed,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OUT_W-1:0]  out_sum,
   output logic              busy
);

   localparam int NLANES = DATA_W / LANE_W;
   localparam int ACC_W  = LANE_W + 1 + $clog2(NLANES);
   localparam int IDX_W  = $clog2(NLANES + 1);
   localparam logic [IDX_W-1:0] STEP     = IDX_W'(LANES_PER_CYC);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NLANES - LANES_PER_CYC);

   generate
      if ((DATA_W % LANE_W != 0) || (NLANES % LANES_PER_CYC != 0) || (OUT_W < ACC_W)) begin : g_bad_cfg
         $error("red_seq_unit: illegal DATA_W/LANE_W/LANES_PER_CYC/OUT_W combination");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   state_t             state_q, state_d;
   logic [DATA_W-1:0]  a_q, a_d, b_q, b_d;
   logic               sgn_q, sgn_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [OUT_W-1:0]   out_sum_q, out_sum_d;
   logic               out_valid_q, out_valid_d;

   logic [DATA_W-1:0]      a_sh, b_sh;
   logic [LANE_W-1:0]      lane_a, lane_b;
   logic [ACC_W-1:0]       acc_next;
   logic [OUT_W+ACC_W-1:0] sum_wide;

   function automatic logic [ACC_W-1:0] ext_lane(input logic [LANE_W-1:0] v, input logic s);
      return {{(ACC_W-LANE_W){s & v[LANE_W-1]}}, v};
   endfunction

   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      sgn_d       = sgn_q;
      acc_d       = acc_q;
      idx_d       = idx_q;
      out_sum_d   = out_sum_q;
      out_valid_d = out_valid_q;

      // Current group of lanes is brought down to bit 0 before slicing.
      a_sh     = a_q >> (idx_q * LANE_W);
      b_sh     = b_q >> (idx_q * LANE_W);
      acc_next = acc_q;
      lane_a   = '0;
      lane_b   = '0;
      for (int j = 0; j < LANES_PER_CYC; j++) begin
         lane_a   = a_sh[j*LANE_W +: LANE_W];
         lane_b   = b_sh[j*LANE_W +: LANE_W];
         acc_next = acc_next + ext_lane(lane_a, sgn_q) + ext_lane(lane_b, sgn_q);
      end
      sum_wide = {{OUT_W{sgn_q & acc_next[ACC_W-1]}}, acc_next};

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = in_a;
               b_d     = in_b;
               sgn_d   = in_signed;
               acc_d   = '0;
               idx_d   = '0;
               state_d = ACCUM;
            end
         end
         ACCUM: begin
            acc_d = acc_next;
            idx_d = idx_q + STEP;
            if (idx_q == LAST_IDX) begin
               out_sum_d   = sum_wide[OUT_W-1:0];
               out_valid_d = 1'b1;
               state_d     = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         sgn_q       <= 1'b0;
         acc_q       <= '0;
         idx_q       <= '0;
         out_sum_q   <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         sgn_q       <= sgn_d;
         acc_q       <= acc_d;
         idx_q       <= idx_d;
         out_sum_q   <= out_sum_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign out_valid = out_valid_q;
   assign out_sum   = out_sum_q;

endmodule

// File: tb/tb_red_seq_unit.sv
// Directed bench for red_seq_unit: three LANES_PER_CYC variants driven in
// lockstep plus a 32-bit/8-bit-lane variant.
module tb_red_seq_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0, in_signed = 1'b0, out_ready = 1'b1;
   logic [15:0] in_a = '0, in_b = '0;
   logic [2:0]  ir, ov, bz;
   logic [15:0] os [3];

   logic        v32 = 1'b0;
   logic [31:0] a32 = '0, b32 = '0;
   logic        ir32, ov32, bz32;
   logic [15:0] os32;

   int nvec  = 0;
   int nfail = 0;
   int glat [3] = '{2, 4, 1};

   always #5 clk = ~clk;

   red_seq_unit dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .in_a(in_a), .in_b(in_b),
      .in_signed(in_signed), .out_valid(ov[0]), .out_ready(out_ready), .out_sum(os[0]), .busy(bz[0]));
   red_seq_unit #(.LANES_PER_CYC(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .in_a(in_a), .in_b(in_b),
      .in_signed(in_signed), .out_valid(ov[1]), .out_ready(out_ready), .out_sum(os[1]), .busy(bz[1]));
   red_seq_unit #(.LANES_PER_CYC(4)) dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .in_a(in_a), .in_b(in_b),
      .in_signed(in_signed), .out_valid(ov[2]), .out_ready(out_ready), .out_sum(os[2]), .busy(bz[2]));
   red_seq_unit #(.DATA_W(32), .LANE_W(8)) dut32 (
      .clk(clk), .rst(rst), .in_valid(v32), .in_ready(ir32), .in_a(a32), .in_b(b32),
      .in_signed(in_signed), .out_valid(ov32), .out_ready(out_ready), .out_sum(os32), .busy(bz32));

   task automatic test_reset();
      @(negedge clk);
      @(negedge clk);
      nvec++; if ({ov, ov32} !== 4'b0000) begin nfail++; $display("FAIL reset out_valid got %b want 0000", {ov, ov32}); end
      nvec++; if ({ir, ir32} !== 4'b1111) begin nfail++; $display("FAIL reset in_ready got %b want 1111", {ir, ir32}); end
      nvec++; if ({bz, bz32} !== 4'b0000) begin nfail++; $display("FAIL reset busy got %b want 0000", {bz, bz32}); end
      for (int i = 0; i < 3; i++) begin
         nvec++; if (os[i] !== 16'h0000) begin nfail++; $display("FAIL reset out_sum dut%0d got %h want 0000", i, os[i]); end
      end
      nvec++; if (os32 !== 16'h0000) begin nfail++; $display("FAIL reset out_sum dut32 got %h want 0000", os32); end
      rst = 1'b0;
   endtask

   // One transaction with out_ready=1; inputs are scrambled after acceptance.
   task automatic test_txn(input logic [15:0] a, input logic [15:0] b, input logic s,
                           input logic [15:0] exp, input string nm);
      int          lat [3];
      logic [15:0] got [3];
      logic [2:0]  ir_done;
      lat = '{-1, -1, -1};
      got = '{16'h0, 16'h0, 16'h0};
      ir_done = 3'b111;
      @(negedge clk);
      in_valid = 1'b1; in_a = a; in_b = b; in_signed = s; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; in_a = ~a; in_b = ~b; in_signed = ~s;
      for (int m = 0; m < 7; m++) begin
         if (m > 0) @(negedge clk);
         for (int i = 0; i < 3; i++)
            if (ov[i] === 1'b1 && lat[i] < 0) begin
               lat[i] = m; got[i] = os[i]; ir_done[i] = ir[i];
            end
      end
      for (int i = 0; i < 3; i++) begin
         nvec++; if (lat[i] != glat[i]) begin nfail++; $display("FAIL %s latency dut%0d got %0d want %0d", nm, i, lat[i], glat[i]); end
         nvec++; if (got[i] !== exp) begin nfail++; $display("FAIL %s sum dut%0d got %h want %h", nm, i, got[i], exp); end
         nvec++; if (ir_done[i] !== 1'b0) begin nfail++; $display("FAIL %s in_ready_in_done dut%0d got %b want 0", nm, i, ir_done[i]); end
         nvec++; if (ir[i] !== 1'b1) begin nfail++; $display("FAIL %s in_ready_after dut%0d got %b want 1", nm, i, ir[i]); end
      end
   endtask

   task automatic test_backpressure();
      int seen;
      seen = 0;
      @(negedge clk);
      in_valid = 1'b1; in_a = 16'h7777; in_b = 16'h7777; in_signed = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      for (int m = 0; m < 10 && seen == 0; m++) begin
         @(negedge clk);
         if (ov[0] === 1'b1) seen = 1;
      end
      nvec++; if (seen != 1) begin nfail++; $display("FAIL bp out_valid_timeout got %0d want 1", seen); end
      for (int c = 0; c < 5; c++) begin
         nvec++; if (os[0] !== 16'h0038) begin nfail++; $display("FAIL bp hold_sum cyc%0d got %h want 0038", c, os[0]); end
         nvec++; if ({ov[0], ir[0]} !== 2'b10) begin nfail++; $display("FAIL bp hold_valid_ready cyc%0d got %b want 10", c, {ov[0], ir[0]}); end
         in_valid = 1'b1; in_a = 16'h1111 + 16'(c); in_b = 16'h2222; in_signed = 1'b0;
         @(negedge clk);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      nvec++; if (ov !== 3'b000) begin nfail++; $display("FAIL bp release_valid got %b want 000", ov); end
      nvec++; if (ir !== 3'b111) begin nfail++; $display("FAIL bp release_ready got %b want 111", ir); end
      nvec++; if (os[0] !== 16'h0038) begin nfail++; $display("FAIL bp sum_kept got %h want 0038", os[0]); end
      @(negedge clk);
      nvec++; if (bz !== 3'b000) begin nfail++; $display("FAIL bp no_accept busy got %b want 000", bz); end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      in_valid = 1'b1; in_a = 16'h1234; in_b = 16'hFFFF; in_signed = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      nvec++; if (ov !== 3'b000) begin nfail++; $display("FAIL rstmid out_valid got %b want 000", ov); end
      nvec++; if (ir !== 3'b111) begin nfail++; $display("FAIL rstmid in_ready got %b want 111", ir); end
      nvec++; if (bz !== 3'b000) begin nfail++; $display("FAIL rstmid busy got %b want 000", bz); end
      for (int i = 0; i < 3; i++) begin
         nvec++; if (os[i] !== 16'h0000) begin nfail++; $display("FAIL rstmid out_sum dut%0d got %h want 0000", i, os[i]); end
      end
      test_txn(16'h7777, 16'h7777, 1'b1, 16'h0038, "after_rst");
   endtask

   task automatic test_wide_lanes();
      int lat;
      logic [15:0] got;
      lat = -1; got = '0;
      @(negedge clk);
      v32 = 1'b1; a32 = 32'hFFFF_FFFF; b32 = 32'hFFFF_FFFF; in_signed = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      v32 = 1'b0; a32 = '0; b32 = '0; in_signed = 1'b1;
      for (int m = 0; m < 6; m++) begin
         if (m > 0) @(negedge clk);
         if (ov32 === 1'b1 && lat < 0) begin lat = m; got = os32; end
      end
      nvec++; if (lat != 2) begin nfail++; $display("FAIL wide latency got %0d want 2", lat); end
      nvec++; if (got !== 16'h07F8) begin nfail++; $display("FAIL wide sum got %h want 07f8", got); end
      nvec++; if (ir32 !== 1'b1) begin nfail++; $display("FAIL wide in_ready_after got %b want 1", ir32); end
   endtask

   initial begin
      test_reset();
      test_txn(16'h7777, 16'h7777, 1'b1, 16'h0038, "s_7777");
      test_txn(16'h8888, 16'h8888, 1'b1, 16'hFFC0, "s_8888");
      test_txn(16'h8888, 16'h8888, 1'b0, 16'h0040, "u_8888");
      test_txn(16'hFFFF, 16'hFFFF, 1'b0, 16'h0078, "u_ffff");
      test_txn(16'h1234, 16'hFFFF, 1'b1, 16'h0006, "s_1234_ffff");
      test_backpressure();
      test_reset_mid();
      test_wide_lanes();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule

// File: doc/red_seq_unit.md
Name: red_seq_unit

Overview:
- Parametrised, multi-cycle successor to the single-cycle RED reduction datapath.
- Splits two DATA_W operands into LANE_W-bit lanes and forms the sum of every lane of A plus every lane of B.
- Processes LANES_PER_CYC lane pairs per clock with a per-transaction signed/unsigned mode.
- Result is extended to OUT_W bits.
- Sits beside the ALU/execute stage behind a valid/ready handshake, so the pipeline can stall on it.

Parameters:
- DATA_W, 16, operand width.
- LANE_W, 4, width of one reduction lane.
- LANES_PER_CYC, 2, lane pairs accumulated per ACCUM cycle.
- OUT_W, 16, result width.
- Derived values:
  - NLANES = DATA_W/LANE_W.
  - G = NLANES/LANES_PER_CYC, the number of ACCUM cycles.
  - ACC_W = LANE_W + 1 + clog2(NLANES).
- Legal configurations:
  - DATA_W % LANE_W == 0.
  - NLANES % LANES_PER_CYC == 0.
  - OUT_W >= ACC_W.
  - Any violation triggers an elaboration-time $error.

Ports:
- clk        in   1       clock, all state changes on rising edge
- rst        in   1       synchronous active-high reset
- in_valid   in   1       request valid
- in_ready   out  1       unit can accept a request
- in_a       in   DATA_W  operand A
- in_b       in   DATA_W  operand B
- in_signed  in   1       1: lanes are two's complement; 0: lanes are unsigned
- out_valid  out  1       result valid
- out_ready  in   1       consumer accepts result
- out_sum    out  OUT_W   extended reduction result
- busy       out  1       high in ACCUM or DONE

Behaviour:
- Reset (rst=1 at an edge) applies in any state, including mid-ACCUM or DONE; the in-flight transaction is discarded. It forces:
  - state=IDLE, acc=0, idx=0.
  - out_valid=0, out_sum=0, busy=0, in_ready=1 (in_ready is combinational from state).
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, latch in_a, in_b and in_signed; acc<=0; idx<=0; go to ACCUM.
  - Otherwise stay in IDLE.
- ACCUM:
  - in_ready=0.
  - Each edge adds lane pairs idx..idx+LANES_PER_CYC-1 to acc. Each lane is sign-extended (mode 1) or zero-extended (mode 0) to ACC_W before adding.
  - idx += LANES_PER_CYC.
  - On the edge that processes the last group: out_sum <= acc_next extended to OUT_W (sign-extended if mode=1, zero-extended if mode=0); out_valid<=1; go to DONE.
- DONE:
  - in_ready=0.
  - out_sum and out_valid hold stable until an edge with out_ready=1. That edge sets out_valid<=0 and returns to IDLE.
  - out_sum keeps its last value after the handshake.
- Latency:
  - Request accepted at edge k; out_valid is high after edge k+G (k+2 with defaults).
  - Earliest next acceptance is edge k+G+2.
  - No back-to-back overlap: in_ready stays 0 during the DONE handshake cycle.
- Requests are ignored whenever in_ready=0. Latched operands are unaffected by input changes after acceptance.
- Arithmetic:
  - ACC_W guarantees no overflow for any input.
  - Mode is fixed per transaction at acceptance.
- out_ready while out_valid=0 has no effect.

Test Plan:
- Signed, in_a=0x7777, in_b=0x7777, out_ready=1 -> out_valid high 2 cycles after acceptance, out_sum=0x0038 (56), then IDLE and in_ready=1.
- Signed, in_a=0x8888, in_b=0x8888 -> out_sum=0xFFC0 (-64). Same operands unsigned -> out_sum=0x0040. Unsigned, 0xFFFF+0xFFFF -> out_sum=0x0078.
- Signed, in_a=0x1234, in_b=0xFFFF -> out_sum=0x0006.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles after out_valid rises, pulsing in_valid with new operands throughout.
  - Required response: out_sum stays stable, in_ready=0, the new requests are not accepted, and the unit returns to IDLE one edge after out_ready=1.
- Reset mid-operation:
  - Stimulus: assert rst for 1 cycle during ACCUM, then send signed 0x7777/0x7777.
  - Required response: out_valid=0, out_sum=0 and in_ready=1 after the reset edge, then the next result is 0x0038 with normal latency.
- Parameter sweep:
  - LANES_PER_CYC=1 -> latency 4 cycles, same results as the cases above.
  - LANES_PER_CYC=4 -> latency 1 cycle.
  - DATA_W=32, LANE_W=8, unsigned, all-ones operands -> out_sum=0x07F8 (2040).
